// File: rtl/c2f_checksum_pkg.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : c2f_checksum_pkg
// Brief    : Types and constants for the C2F checksum consumer.
// Revision : 1.0
// ============================================================================
package c2f_checksum_pkg;

  localparam int RATE_NBITS_DEFAULT = 8;

  typedef logic [RATE_NBITS_DEFAULT-1:0] Rate;

  localparam Rate GOBBLE = '0;

  typedef enum logic [2:0] {
    S_IDLE     = 3'd0,
    S_READ     = 3'd1,
    S_DRAIN    = 3'd2,
    S_ACK      = 3'd3,
    S_WAIT_PTR = 3'd4
  } State;

endpackage
`default_nettype wire

// File: rtl/tlp_xcvr_pkg.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : tlp_xcvr_pkg
// Brief    : C2F chunk geometry shared with tlp_xcvr (128-byte chunks, 4 slots).
// Revision : 1.0
// ============================================================================
package tlp_xcvr_pkg;

  localparam int C2F_CHUNKSIZE         = 128;
  localparam int C2F_CHUNKPTR_NBITS    = 2;
  localparam int C2F_CHUNKOFFSET_NBITS = $clog2(C2F_CHUNKSIZE / 8);

  typedef logic [C2F_CHUNKPTR_NBITS-1:0]    C2FChunkPtr;
  typedef logic [C2F_CHUNKOFFSET_NBITS-1:0] C2FChunkOffset;

endpackage
`default_nettype wire

// File: rtl/c2f_rate_gate.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : c2f_rate_gate
// Brief    : Read throttle down-counter; loaded on each read, open at zero.
// Revision : 1.0
// ============================================================================
module c2f_rate_gate #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_clr,
  input  logic             i_load,
  input  logic [WIDTH-1:0] i_rate,
  output logic             o_open
);

  logic [WIDTH-1:0] r_count;

  assign o_open = (r_count == '0);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_count <= '0;
    end else if (i_clr) begin
      // Guarantees the first read of a chunk is never delayed.
      r_count <= '0;
    end else if (i_load) begin
      r_count <= i_rate;
    end else if (r_count != '0) begin
      r_count <= r_count - 1'b1;
    end
  end

endmodule
`default_nettype wire

// File: rtl/c2f_checksum_consumer.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : c2f_checksum_consumer
// Brief    : Drains committed C2F chunks, sums QWs mod 2^64, acks, publishes.
//            Optional read throttle: C2F_CONSUMER_THROTTLE_EN.
// Revision : 1.0
// ============================================================================
module c2f_checksum_consumer
  import tlp_xcvr_pkg::*;
  import c2f_checksum_pkg::*;
#(
  parameter int RATE_NBITS = RATE_NBITS_DEFAULT
) (
  input  logic                  pcieClk_in,
  input  logic                  reset_in,
  input  C2FChunkPtr            wrPtr_in,
  input  C2FChunkPtr            rdPtr_in,
  output logic                  dtAck_out,
  output C2FChunkOffset         rdOffset_out,
  input  logic [63:0]           rdData_in,
  output logic [63:0]           csData_out,
  output logic                  csValid_out,
  input  logic [RATE_NBITS-1:0] rate_in
);

  localparam C2FChunkOffset c_LAST_OFFSET = C2FChunkOffset'(C2F_CHUNKSIZE / 8 - 1);

  State        r_state;
  C2FChunkPtr  r_curPtr;
  logic [63:0] r_acc;
  logic        r_rdValid;
  logic        w_gateOpen;
  logic        w_readFire;
  logic        w_inIdle;

  assign w_inIdle   = (r_state == S_IDLE);
  assign w_readFire = (r_state == S_READ) && w_gateOpen;

`ifdef C2F_CONSUMER_THROTTLE_EN
  c2f_rate_gate #(
    .WIDTH (RATE_NBITS)
  ) u_rate_gate (
    .clk    (pcieClk_in),
    .rst    (reset_in),
    .i_clr  (w_inIdle),
    .i_load (w_readFire),
    .i_rate (rate_in),
    .o_open (w_gateOpen)
  );
`else
  logic w_unused_rate;
  assign w_unused_rate = ^rate_in;
  assign w_gateOpen    = 1'b1;
`endif

  always_ff @(posedge pcieClk_in or posedge reset_in) begin
    if (reset_in) begin
      r_state      <= S_IDLE;
      r_curPtr     <= '0;
      r_acc        <= '0;
      r_rdValid    <= 1'b0;
      dtAck_out    <= 1'b0;
      rdOffset_out <= '0;
      csData_out   <= '0;
      csValid_out  <= 1'b1;
    end else begin
      dtAck_out <= 1'b0;
      // RAM data lags its offset by one cycle; the flag follows the same lag.
      r_rdValid <= w_readFire;
      if (r_rdValid) begin
        r_acc <= r_acc + rdData_in;
      end

      case (r_state)
        S_IDLE: begin
          rdOffset_out <= '0;
          if (wrPtr_in != rdPtr_in) begin
            r_curPtr    <= rdPtr_in;
            r_acc       <= '0;
            csValid_out <= 1'b0;
            r_state     <= S_READ;
          end
        end
        S_READ: begin
          if (w_readFire) begin
            if (rdOffset_out == c_LAST_OFFSET) begin
              rdOffset_out <= '0;
              r_state      <= S_DRAIN;
            end else begin
              rdOffset_out <= rdOffset_out + 1'b1;
            end
          end
        end
        S_DRAIN: begin
          dtAck_out <= 1'b1;
          r_state   <= S_ACK;
        end
        S_ACK: begin
          csData_out  <= r_acc;
          csValid_out <= 1'b1;
          r_state     <= S_WAIT_PTR;
        end
        S_WAIT_PTR: begin
          // Hold off until tlp_xcvr has retired this chunk's pointer.
          if (rdPtr_in != r_curPtr) begin
            r_state <= S_IDLE;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_c2f_checksum_consumer.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : tb_c2f_checksum_consumer
// Brief    : Directed self-checking bench for c2f_checksum_consumer.
// Revision : 1.0
// ============================================================================
module tb_c2f_checksum_consumer;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [1:0]  wrPtr = 2'd0;
  logic [1:0]  rdPtr = 2'd0;
  logic        dtAck;
  logic [3:0]  rdOff;
  logic [63:0] rdData = 64'd0;
  logic [63:0] csData;
  logic        csValid;
  logic [7:0]  rate = 8'd0;

  logic [63:0] mem [0:3][0:15];

  int n_vec = 0;
  int n_err = 0;

`ifdef C2F_CONSUMER_THROTTLE_EN
  localparam int LAT_R3 = 63;
  localparam int LAT_R9 = 153;
`else
  localparam int LAT_R3 = 18;
  localparam int LAT_R9 = 18;
`endif

  c2f_checksum_consumer #(.RATE_NBITS(8)) dut (
    .pcieClk_in   (clk),
    .reset_in     (rst),
    .wrPtr_in     (wrPtr),
    .rdPtr_in     (rdPtr),
    .dtAck_out    (dtAck),
    .rdOffset_out (rdOff),
    .rdData_in    (rdData),
    .csData_out   (csData),
    .csValid_out  (csValid),
    .rate_in      (rate)
  );

  always #5 clk = ~clk;

  always @(posedge clk) rdData <= mem[rdPtr][rdOff];

  task automatic fill_seq(input logic [1:0] p);
    for (int i = 0; i < 16; i++) mem[p][i] = 64'(i + 1);
  endtask

  task automatic fill_const(input logic [1:0] p, input logic [63:0] v);
    for (int i = 0; i < 16; i++) mem[p][i] = v;
  endtask

  // Called at a negedge with a chunk just made visible; measures cycles to ack.
  task automatic consume(output int lat, output logic vf, output logic va,
                         output logic an, output logic vn, output logic [63:0] dn);
    lat = -1;
    vf  = 1'bx;
    va  = 1'bx;
    for (int k = 1; k <= 400; k++) begin
      @(posedge clk);
      @(negedge clk);
      if (k == 1) vf = csValid;
      if (dtAck === 1'b1) begin
        lat = k;
        va  = csValid;
        break;
      end
    end
    @(posedge clk);
    @(negedge clk);
    an = dtAck;
    vn = csValid;
    dn = csData;
  endtask

  task automatic release_chunk();
    rdPtr = rdPtr + 2'd1;
    repeat (3) @(negedge clk);
  endtask

  task automatic test_reset();
    repeat (3) @(negedge clk);
    n_vec++; if (dtAck !== 1'b0) begin n_err++; $display("FAIL reset_ack got %0b want 0", dtAck); end
    n_vec++; if (rdOff !== 4'd0) begin n_err++; $display("FAIL reset_offset got %0d want 0", rdOff); end
    n_vec++; if (csData !== 64'd0) begin n_err++; $display("FAIL reset_csdata got %h want 0", csData); end
    n_vec++; if (csValid !== 1'b1) begin n_err++; $display("FAIL reset_csvalid got %0b want 1", csValid); end
    rst = 1'b0;
    repeat (2) @(negedge clk);
    n_vec++; if (dtAck !== 1'b0) begin n_err++; $display("FAIL idle_ack got %0b want 0", dtAck); end
    n_vec++; if (csValid !== 1'b1) begin n_err++; $display("FAIL idle_csvalid got %0b want 1", csValid); end
  endtask

  task automatic test_basic();
    int lat; logic vf, va, an, vn; logic [63:0] dn;
    fill_seq(rdPtr);
    wrPtr = rdPtr + 2'd1;
    consume(lat, vf, va, an, vn, dn);
    n_vec++; if (lat != 18) begin n_err++; $display("FAIL basic_latency got %0d want 18", lat); end
    n_vec++; if (vf !== 1'b0) begin n_err++; $display("FAIL basic_valid_busy got %0b want 0", vf); end
    n_vec++; if (va !== 1'b0) begin n_err++; $display("FAIL basic_valid_at_ack got %0b want 0", va); end
    n_vec++; if (an !== 1'b0) begin n_err++; $display("FAIL basic_ack_width got %0b want 0", an); end
    n_vec++; if (vn !== 1'b1) begin n_err++; $display("FAIL basic_valid_after got %0b want 1", vn); end
    n_vec++; if (dn !== 64'h88) begin n_err++; $display("FAIL basic_sum got %h want 88", dn); end
    release_chunk();
  endtask

  task automatic test_wrap();
    int lat; logic vf, va, an, vn; logic [63:0] dn;
    fill_const(rdPtr, 64'hFFFF_FFFF_FFFF_FFFF);
    wrPtr = rdPtr + 2'd1;
    consume(lat, vf, va, an, vn, dn);
    n_vec++; if (lat != 18) begin n_err++; $display("FAIL wrap_latency got %0d want 18", lat); end
    n_vec++; if (dn !== 64'hFFFF_FFFF_FFFF_FFF0) begin n_err++; $display("FAIL wrap_sum got %h want fffffffffffffff0", dn); end
    n_vec++; if (vn !== 1'b1) begin n_err++; $display("FAIL wrap_valid_after got %0b want 1", vn); end
    release_chunk();
  endtask

  task automatic test_rate();
    int lat; logic vf, va, an, vn; logic [63:0] dn;
    rate = 8'd3;
    fill_seq(rdPtr);
    wrPtr = rdPtr + 2'd1;
    consume(lat, vf, va, an, vn, dn);
    n_vec++; if (lat != LAT_R3) begin n_err++; $display("FAIL rate3_latency got %0d want %0d", lat, LAT_R3); end
    n_vec++; if (dn !== 64'h88) begin n_err++; $display("FAIL rate3_sum got %h want 88", dn); end
    n_vec++; if (an !== 1'b0) begin n_err++; $display("FAIL rate3_ack_width got %0b want 0", an); end
    rate = 8'd0;
    release_chunk();
  endtask

  task automatic test_back_to_back();
    int lat; logic vf, va, an, vn; logic [63:0] dn;
    logic [63:0] exp_sum [0:3];
    exp_sum[0] = 64'h40078;
    exp_sum[1] = 64'h10078;
    exp_sum[2] = 64'h20078;
    exp_sum[3] = 64'h30078;
    for (int j = 0; j < 4; j++) begin
      for (int i = 0; i < 16; i++) mem[rdPtr][i] = 64'h1000 * 64'(rdPtr + 1) + 64'(i);
      wrPtr = rdPtr + 2'd1;
      consume(lat, vf, va, an, vn, dn);
      n_vec++; if (lat != 18) begin n_err++; $display("FAIL b2b%0d_latency got %0d want 18", j, lat); end
      n_vec++; if (dn !== exp_sum[j]) begin n_err++; $display("FAIL b2b%0d_sum got %h want %h", j, dn, exp_sum[j]); end
      for (int c = 0; c < 5; c++) begin
        @(negedge clk);
        n_vec++; if (dtAck !== 1'b0) begin n_err++; $display("FAIL b2b%0d_dup_ack cycle %0d got %0b want 0", j, c, dtAck); end
      end
      release_chunk();
    end
  endtask

  task automatic test_reset_midchunk();
    int lat; logic vf, va, an, vn; logic [63:0] dn;
    fill_seq(rdPtr);
    wrPtr = rdPtr + 2'd1;
    for (int k = 1; k <= 7; k++) begin
      @(posedge clk);
      @(negedge clk);
    end
    n_vec++; if (rdOff !== 4'd6) begin n_err++; $display("FAIL mid_offset_read7 got %0d want 6", rdOff); end
    rst = 1'b1;
    #1;
    n_vec++; if (dtAck !== 1'b0) begin n_err++; $display("FAIL mid_reset_ack got %0b want 0", dtAck); end
    n_vec++; if (rdOff !== 4'd0) begin n_err++; $display("FAIL mid_reset_offset got %0d want 0", rdOff); end
    n_vec++; if (csData !== 64'd0) begin n_err++; $display("FAIL mid_reset_csdata got %h want 0", csData); end
    n_vec++; if (csValid !== 1'b1) begin n_err++; $display("FAIL mid_reset_csvalid got %0b want 1", csValid); end
    repeat (2) @(negedge clk);
    n_vec++; if (dtAck !== 1'b0) begin n_err++; $display("FAIL mid_reset_held_ack got %0b want 0", dtAck); end
    rst = 1'b0;
    consume(lat, vf, va, an, vn, dn);
    n_vec++; if (lat != 18) begin n_err++; $display("FAIL mid_redo_latency got %0d want 18", lat); end
    n_vec++; if (dn !== 64'h88) begin n_err++; $display("FAIL mid_redo_sum got %h want 88", dn); end
    n_vec++; if (vn !== 1'b1) begin n_err++; $display("FAIL mid_redo_valid got %0b want 1", vn); end
    release_chunk();
  endtask

  task automatic test_rate9();
    int lat; logic vf, va, an, vn; logic [63:0] dn;
    rate = 8'd9;
    fill_const(rdPtr, 64'd5);
    wrPtr = rdPtr + 2'd1;
    consume(lat, vf, va, an, vn, dn);
    n_vec++; if (lat != LAT_R9) begin n_err++; $display("FAIL rate9_latency got %0d want %0d", lat, LAT_R9); end
    n_vec++; if (dn !== 64'h50) begin n_err++; $display("FAIL rate9_sum got %h want 50", dn); end
    rate = 8'd0;
    release_chunk();
  endtask

  initial begin
    for (int p = 0; p < 4; p++) fill_const(2'(p), 64'd0);
    test_reset();
    test_basic();
    test_wrap();
    test_rate();
    test_back_to_back();
    test_reset_midchunk();
    test_rate9();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
`default_nettype wire
